// File: rtl/fp_issue_sequencer.sv
// fp_issue_sequencer
//   Sits between the ID/EX FP outputs and a multi-cycle FPU core. Each FP
//   instruction in EX becomes one fpu_start pulse. The pipeline is held with
//   stall_req while the FPU is busy. The result is captured into a register and
//   presented for exactly one cycle together with its destination register.
//   A flush (kill_e) of an in-flight op drains the FPU without a regfile write.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   fp_valid_e, fp_op_e      FP instruction present in EX and its FPU control
//   fp_rs1_e, fp_rs2_e       forwarded operands
//   fp_rd_e                  destination FP register
//   kill_e                   flush of the EX stage
//   fpu_busy, fpu_data       FPU stall flag and result
//   fpu_start                one-cycle start pulse to the FPU
//   fpu_op, fpu_rs1/2        latched op and operands to the FPU
//   stall_req                freeze F/D/E, bubble M
//   res_valid, res_data      one-cycle result strobe and captured result
//   res_rd                   destination register of the result
//   seq_busy                 sequencer not idle
//   fp_err                   sticky watchdog error
//
// Optional feature: define FP_TIMEOUT_EN to add a WAIT/DRAIN watchdog of
// TIMEOUT_CYC cycles. Without it the sequencer waits on the FPU indefinitely
// and fp_err is tied low.

module fp_issue_sequencer #(
    parameter int DATA_W      = 32,
    parameter int OP_W        = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fp_valid_e,
    input  logic [OP_W-1:0]   fp_op_e,
    input  logic [DATA_W-1:0] fp_rs1_e,
    input  logic [DATA_W-1:0] fp_rs2_e,
    input  logic [4:0]        fp_rd_e,
    input  logic              kill_e,
    input  logic              fpu_busy,
    input  logic [DATA_W-1:0] fpu_data,
    output logic              fpu_start,
    output logic [OP_W-1:0]   fpu_op,
    output logic [DATA_W-1:0] fpu_rs1,
    output logic [DATA_W-1:0] fpu_rs2,
    output logic              stall_req,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_rd,
    output logic              seq_busy,
    output logic              fp_err
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

`ifdef FP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    // Counter holds the number of WAIT/DRAIN cycles already completed, so the
    // TIMEOUT_CYC-th cycle is the one where it reads TIMEOUT_CYC-1.
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT || state_q == S_DRAIN)
            cnt_d = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        res_data_d = res_data_q;
        fpu_start  = 1'b0;
        stall_req  = 1'b0;
        res_valid  = 1'b0;
`ifdef FP_TIMEOUT_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Gate on rst so a held fp_valid_e cannot raise stall_req
                // while the block is in reset.
                if (rst && fp_valid_e && !kill_e) begin
                    op_d      = fp_op_e;
                    rs1_d     = fp_rs1_e;
                    rs2_d     = fp_rs2_e;
                    rd_d      = fp_rd_e;
                    stall_req = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start = 1'b1;
                stall_req = 1'b1;
                state_d   = kill_e ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (kill_e) begin
                    state_d = S_DRAIN;
                end else if (!fpu_busy) begin
                    res_data_d = fpu_data;
                    state_d    = S_DONE;
                end
`ifdef FP_TIMEOUT_EN
                else if (timeout) begin
                    res_data_d = DATA_W'(32'h7FC0_0000);
                    err_d      = 1'b1;
                    state_d    = S_DONE;
                end
`endif
            end
            S_DONE: begin
                res_valid = !kill_e;
                state_d   = S_IDLE;
            end
            S_DRAIN: begin
                // A new FP op arriving in EX must wait for the FPU to drain.
                stall_req = fp_valid_e;
                if (!fpu_busy) begin
                    state_d = S_IDLE;
                end
`ifdef FP_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            res_data_q <= '0;
`ifdef FP_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            res_data_q <= res_data_d;
`ifdef FP_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign fpu_op   = op_q;
    assign fpu_rs1  = rs1_q;
    assign fpu_rs2  = rs2_q;
    assign res_data = res_data_q;
    assign res_rd   = rd_q;
    assign seq_busy = (state_q != S_IDLE);
`ifdef FP_TIMEOUT_EN
    assign fp_err   = err_q;
`else
    assign fp_err   = 1'b0;
`endif

endmodule
